// File: rtl/apb_mem_slave.sv
// APB slave fronting a DEPTH-word register memory; out-of-range accesses answer with pslverr.
// Define APB_WAIT_STATE_EN to insert WAIT_CYCLES access wait states (default build: zero-wait).
module apb_mem_slave #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] padd,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic              wr_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              setup, done, addr_ok, rd_ok, we;

   assign setup   = (state == IDLE) && psel && !penable;
   assign done    = (state == ACCESS) && psel && penable && pready;
   assign addr_ok = {1'b0, addr_q} < DEPTH_L;
   assign rd_ok   = {1'b0, padd} < DEPTH_L;
   assign we      = done && wr_q && addr_ok;
   assign pslverr = pready && !addr_ok;

`ifdef APB_WAIT_STATE_EN
   localparam logic [3:0] EFF_WAIT = 4'(WAIT_CYCLES);
   logic [3:0] wcnt;

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset)
         wcnt <= '0;
      else if (setup)
         wcnt <= '0;
      else if (state == ACCESS && !pready && psel && wcnt != 4'hf)
         wcnt <= wcnt + 4'd1;
   end

   assign pready = (state == ACCESS) && (wcnt == EFF_WAIT);
`else
   // Zero-wait build: WAIT_CYCLES has no effect here.
   localparam int unused_wait = WAIT_CYCLES;
   assign pready = (state == ACCESS);
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (psel && !penable) state_nxt = ACCESS;
         ACCESS:  if (!psel || (penable && pready)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Read data is fetched at the setup edge so it is stable for the whole access phase.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         state  <= IDLE;
         addr_q <= '0;
         wr_q   <= 1'b0;
         prdata <= '0;
      end else begin
         state <= state_nxt;
         if (setup) begin
            addr_q <= padd;
            wr_q   <= pwrite;
            if (!pwrite)
               prdata <= rd_ok ? mem[padd[IDX_W-1:0]] : '0;
         end
      end
   end

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[addr_q[IDX_W-1:0]] <= pwdata;
      end
   end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Table-driven APB bench for apb_mem_slave with a scoreboard queue of expected completions.
`timescale 1ns/1ps
module tb_apb_mem_slave;

   localparam int DATA_W      = 32;
   localparam int ADDR_W      = 8;
   localparam int DEPTH       = 64;
   localparam int WAIT_CYCLES = 3;
`ifdef APB_WAIT_STATE_EN
   localparam int EXP_WAIT = WAIT_CYCLES;
`else
   localparam int EXP_WAIT = 0;
`endif

   logic              pclk = 1'b0;
   logic              preset = 1'b0;
   logic              psel = 1'b0;
   logic              penable = 1'b0;
   logic              pwrite = 1'b0;
   logic [ADDR_W-1:0] padd = '0;
   logic [DATA_W-1:0] pwdata = '0;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   int checks = 0;
   int failures = 0;

   always #5 pclk = ~pclk;

   apb_mem_slave #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)
   ) dut (
      .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .padd(padd), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   typedef struct {
      logic              wr;
      logic              b2b;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] exp_rdata;
      logic              exp_err;
   } vec_t;

   typedef struct {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } exp_t;

   exp_t sbq[$];
   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Entered and left just after a falling edge.
   task automatic xfer(input vec_t v, input string tag);
      exp_t e;
      int   waits;
      if (!v.b2b) begin
         psel = 1'b0; penable = 1'b0;
         @(negedge pclk);
      end
      psel = 1'b1; penable = 1'b0; pwrite = v.wr; padd = v.addr; pwdata = v.wdata;
      sbq.push_back('{v.exp_rdata, v.exp_err});
      chk({tag, "_setup_pready"}, 64'(pready), 64'd0);
      @(negedge pclk);
      penable = 1'b1;
      waits = 0;
      while (pready !== 1'b1 && waits < 40) begin
         @(negedge pclk);
         waits++;
      end
      chk({tag, "_wait_cycles"}, 64'(waits), 64'(EXP_WAIT));
      if (sbq.size() == 0) begin
         checks++; failures++;
         $display("FAIL %s_scoreboard actual=empty required=entry", tag);
      end else begin
         e = sbq.pop_front();
         chk({tag, "_prdata"}, 64'(prdata), 64'(e.rdata));
         chk({tag, "_pslverr"}, 64'(pslverr), 64'(e.err));
      end
      @(negedge pclk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t h;
      vecs[0]  = '{1'b1, 1'b0, 8'd5,   32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 1'b0, 8'd5,   32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 8'd2,   32'h0,        32'h0,        1'b0};
      vecs[3]  = '{1'b1, 1'b0, 8'd63,  32'hA5A5A5A5, 32'h0,        1'b0};
      vecs[4]  = '{1'b1, 1'b0, 8'd64,  32'h11111111, 32'h0,        1'b1};
      vecs[5]  = '{1'b0, 1'b0, 8'd64,  32'h0,        32'h0,        1'b1};
      vecs[6]  = '{1'b0, 1'b0, 8'd63,  32'h0,        32'hA5A5A5A5, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 8'd7,   32'h1,        32'hA5A5A5A5, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 8'd7,   32'h0,        32'h1,        1'b0};
      vecs[9]  = '{1'b0, 1'b0, 8'd255, 32'h0,        32'h0,        1'b1};
      vecs[10] = '{1'b1, 1'b0, 8'd2,   32'h22,       32'h0,        1'b0};
      vecs[11] = '{1'b0, 1'b1, 8'd2,   32'h0,        32'h22,       1'b0};
      vecs[12] = '{1'b1, 1'b0, 8'd0,   32'hCAFEF00D, 32'h22,       1'b0};
      vecs[13] = '{1'b0, 1'b0, 8'd0,   32'h0,        32'hCAFEF00D, 1'b0};

      #1;
      chk("rst_prdata", 64'(prdata), 64'd0);
      chk("rst_pready", 64'(pready), 64'd0);
      chk("rst_pslverr", 64'(pslverr), 64'd0);
      @(negedge pclk);
      preset = 1'b1;

      for (int i = 0; i < 14; i++) xfer(vecs[i], $sformatf("v%0d", i));

      // Abandon a write to address 2 by dropping psel in the access phase.
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      psel = 1'b1; pwrite = 1'b1; padd = 8'd2; pwdata = 32'h99;
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0;
      if (EXP_WAIT > 0) chk("abort_pready_access", 64'(pready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         chk($sformatf("abort_pready_idle%0d", i), 64'(pready), 64'd0);
      end
      chk("abort_prdata_held", 64'(prdata), 64'hCAFEF00D);
      h = '{1'b0, 1'b0, 8'd2, 32'h0, 32'h22, 1'b0};
      xfer(h, "abort_rd2");

      // Reset in the middle of a read access.
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      psel = 1'b1; pwrite = 1'b0; padd = 8'd5;
      @(negedge pclk);
      penable = 1'b1;
      chk("pre_rst_prdata", 64'(prdata), 64'hDEADBEEF);
      #2 preset = 1'b0;
      #1;
      chk("midrst_prdata", 64'(prdata), 64'd0);
      chk("midrst_pready", 64'(pready), 64'd0);
      chk("midrst_pslverr", 64'(pslverr), 64'd0);
      @(negedge pclk);
      psel = 1'b0; penable = 1'b0; preset = 1'b1;
      h = '{1'b0, 1'b0, 8'd5, 32'h0, 32'h0, 1'b0};
      xfer(h, "postrst_rd5");
      h = '{1'b0, 1'b1, 8'd7, 32'h0, 32'h0, 1'b0};
      xfer(h, "postrst_rd7");
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);

      chk("sb_empty", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
